// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for the shift_rows_pipe stage: an input valid/ready
// channel carrying the state and its mode, and an output valid/ready channel
// carrying the permuted state.
interface shift_rows_pipe_if #(
  parameter int STATE_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] code;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] altered;

  // The upstream/downstream environment drives inputs and consumes outputs.
  modport master (
    output in_valid, code, in_inv, out_ready,
    input  in_ready, out_valid, altered
  );

  // The stage itself.
  modport slave (
    input  in_valid, code, in_inv, out_ready,
    output in_ready, out_valid, altered
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage with a 2-entry skid buffer.
// The state is a ROWS x COLS matrix of CELL_W-bit cells, stored column-major
// with cell (r,c) at index k=c*ROWS+r counted from the MSB end.
// Optional build macro SHIFT_ROWS_SELFCHECK_EN: each buffer entry also keeps
// the original input and its mode; at delivery the opposite permutation is
// applied to the outgoing state and compared against it, raising a sticky err.
module shift_rows_pipe #(
  parameter int CELL_W = 4,
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_rows_pipe_if.slave       bus,
  output logic [CNT_W-1:0]       blk_cnt,
  output logic                   err
);

  localparam int STATE_W = CELL_W * ROWS * COLS;

  // Reject degenerate geometries and a bundle whose width disagrees.
  generate
    if (ROWS < 1 || COLS < 1 || CELL_W < 1) begin : g_bad_geometry
      $error("shift_rows_pipe: ROWS, COLS and CELL_W must all be at least 1");
    end
    if ($bits(bus.code) != STATE_W) begin : g_bad_width
      $error("shift_rows_pipe: interface STATE_W does not match CELL_W*ROWS*COLS");
    end
  endgenerate

  // Row r moves left by r (forward) or right by r (inverse); the inverse
  // source column adds COLS before subtracting so nothing goes negative.
  function automatic logic [STATE_W-1:0] permute(
    input logic [STATE_W-1:0] s,
    input logic               inv
  );
    logic [STATE_W-1:0] res;
    int rm, src, k, ks;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rm  = r % COLS;
        src = inv ? ((c + COLS - rm) % COLS) : ((c + rm) % COLS);
        k   = c * ROWS + r;
        ks  = src * ROWS + r;
        res[STATE_W-1-k*CELL_W -: CELL_W] = s[STATE_W-1-ks*CELL_W -: CELL_W];
      end
    end
    return res;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [STATE_W-1:0] data;
`ifdef SHIFT_ROWS_SELFCHECK_EN
    logic               inv;
    logic [STATE_W-1:0] orig;
`endif
  } entry_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t incoming;
  logic   rdy_q;
  logic   vld_q;
  logic   accept;
  logic   deliver;

  // Build the entry that an accepted block would occupy.
  always_comb begin
    incoming      = '0;
    incoming.data = permute(bus.code, bus.in_inv);
`ifdef SHIFT_ROWS_SELFCHECK_EN
    incoming.inv  = bus.in_inv;
    incoming.orig = bus.code;
`endif
  end

  assign accept        = bus.in_valid & rdy_q;
  assign deliver       = vld_q & bus.out_ready;
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.altered   = head.data;

  // Buffer occupancy FSM; head is what is presented, tail is the second slot.
  // In ONE with accept and deliver together the new block replaces head
  // directly, keeping one block per cycle without touching tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      head    <= '0;
      tail    <= '0;
      blk_cnt <= '0;
    end else begin
      if (deliver) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= incoming;
            state <= ONE;
            vld_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            head <= incoming;
          end else if (accept) begin
            tail  <= incoming;
            state <= FULL;
            rdy_q <= 1'b0;
          end else if (deliver) begin
            state <= EMPTY;
            vld_q <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            head  <= tail;
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_ROWS_SELFCHECK_EN
  // Undo the permutation on the outgoing block and flag any disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (deliver && (permute(head.data, ~head.inv) != head.orig)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered ShiftRows / InvShiftRows stage for the cipher datapath.
- Generalises the 16-bit nibble-state permutation to any cell width, row count and column count.
- Adds a runtime encrypt/decrypt mode and a 2-entry skid buffer with valid/ready handshakes, so it drops between SubBytes and MixColumns pipeline stages without breaking backpressure.
- Default configuration is the 16-bit mini-AES state: 2x2 nibbles.

Parameters:
- CELL_W, 4: bits per state cell (4 = nibble state, 8 = byte state).
- ROWS, 2: rows in the state matrix.
- COLS, 2: columns in the state matrix.
- CNT_W, 16: width of the block counter.
- Derived localparam STATE_W = CELL_W*ROWS*COLS.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: code/in_inv is valid.
- in_ready, output, 1: stage can accept a block.
- code, input, STATE_W: input state.
- in_inv, input, 1: 0 = forward ShiftRows, 1 = InvShiftRows; sampled with code.
- out_valid, output, 1: altered is valid.
- out_ready, input, 1: downstream accepts.
- altered, output, STATE_W: permuted state.
- blk_cnt, output, CNT_W: count of blocks delivered.
- err, output, 1: self-check flag (see Optional Feature).

Behaviour:
- State layout is column-major, MSB first. Cell (r,c) has index k=c*ROWS+r and occupies code[STATE_W-1-k*CELL_W -: CELL_W].
- Forward: out(r,c) = in(r,(c+r) mod COLS).
- Inverse: out(r,c) = in(r,(c-r+COLS) mod COLS), computed with no negative intermediates.
- Row 0 is never moved. Rows with r >= COLS wrap modulo COLS.
- The permutation is combinational on code. The permuted result and its mode are written into the buffer on accept.
- Buffer is a 2-entry FIFO. FSM states are EMPTY (0 entries), ONE (1), FULL (2):
  - in_ready = (state != FULL), driven from a register.
  - out_valid = (state != EMPTY).
  - altered = head entry.
  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; deliver only -> EMPTY; accept and deliver in the same cycle -> ONE, with the new block becoming head next cycle.
  - FULL: deliver -> ONE. in_ready is low, so no accept is possible.
- Latency: a block accepted at edge N is presented on altered after edge N when the stage was EMPTY. With out_ready held high, throughput is 1 block/cycle.
- Ordering is strict FIFO. altered and out_valid hold stable while out_valid=1 and out_ready=0.
- blk_cnt increments on each deliver and wraps from 2^CNT_W-1 to 0.
- Reset values: state=EMPTY, in_ready=1, out_valid=0, altered=0, blk_cnt=0, err=0.
- Reset asserted mid-operation discards all buffered blocks immediately; no partial output appears.
- in_valid with in_ready=0 is ignored. The source must hold code stable until accepted.
- Elaboration-time error if ROWS<1, COLS<1 or CELL_W<1.

Optional Feature:
- Macro: SHIFT_ROWS_SELFCHECK_EN.
- Defined: each entry also stores the original input. At deliver, the opposite permutation is applied to altered and compared with the stored input. A mismatch sets err, which is sticky until rst.
- Undefined: no extra storage; err is tied to 0.

Test Plan:
- Default params. Reset, then code=16'h1234, in_inv=0, out_ready=1 -> next cycle out_valid=1, altered=16'h1432, blk_cnt=1 the cycle after.
- Default params. code=16'h1432, in_inv=1 -> altered=16'h1234 (2x2 forward equals inverse).
- CELL_W=8, ROWS=4, COLS=4. code=128'h000102030405060708090a0b0c0d0e0f:
  - in_inv=0 -> 128'h00050a0f04090e03080d02070c01060b.
  - in_inv=1 -> 128'h000d0a0704010e0b0805020f0c090603.
- Backpressure: out_ready=0, push blocks A, B -> in_ready=0 after the 2nd accept and C is stalled. Raise out_ready -> A, B, C delivered in order, one per cycle, with altered stable while stalled.
- Simultaneous accept/deliver in ONE with in_valid and out_ready held high for 10 cycles -> 10 blocks out, state stays ONE, blk_cnt=10.
- Wrap and reset: CNT_W=4, deliver 17 blocks -> blk_cnt=1. Assert rst with the buffer FULL -> out_valid=0 and in_ready=1 immediately, and err=0.
